// File: rtl/uart_pkg.sv
// Shared UART definitions: frame geometry, transmit FSM states and parity helper.
// The receive side imports the same package.
package uart_pkg;

    localparam int UART_DATA_BITS  = 8;
    localparam int UART_OVERSAMPLE = 16;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_tx_state_t;

    // odd=0 gives even parity (bit makes the total count of ones even)
    function automatic logic uart_parity(input logic [UART_DATA_BITS-1:0] d,
                                         input logic                      odd);
        return (^d) ^ odd;
    endfunction

endpackage

// File: rtl/uart_tx.sv
// UART transmitter: one byte per accepted tx_en becomes a start/data/parity/stop frame
// on tx_o, bit-timed solely by the shared oversampling enable.
module uart_tx
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = UART_OVERSAMPLE
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      baud_x16_ce,
    input  logic [UART_DATA_BITS-1:0] tx_data,
    input  logic                      tx_en,
    input  logic                      parity_en,
    input  logic                      parity_odd,
    input  logic                      two_stop,
    output logic                      tx_o,
    output logic                      tx_busy,
    output logic                      tx_done
);

    localparam int TW = $clog2(OVERSAMPLE);

    uart_tx_state_t            state_q, state_d;
    logic [TW-1:0]             tick_q;
    logic [2:0]                bit_q;
    logic [UART_DATA_BITS-1:0] shreg_q, shreg_d;
    logic                      par_en_q, par_bit_q, two_stop_q;
    logic                      tx_q, tx_d;
    logic                      done_q, done_d;
    logic                      busy_q;
    logic                      accept, bit_end, last_stop;

    assign accept    = (state_q == IDLE) && tx_en;
    assign bit_end   = baud_x16_ce && (tick_q == TW'(OVERSAMPLE - 1));
    assign last_stop = two_stop_q ? (bit_q == 3'd1) : (bit_q == 3'd0);

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (tx_en)                     state_d = START;
            START:   if (bit_end)                   state_d = DATA;
            DATA:    if (bit_end && bit_q == 3'd7)  state_d = par_en_q ? PARITY : STOP;
            PARITY:  if (bit_end)                   state_d = STOP;
            STOP:    if (bit_end && last_stop)      state_d = IDLE;
            default:                                state_d = IDLE;
        endcase
    end

    // Tick and bit counters; bit counter restarts at every state change
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tick_q <= '0;
            bit_q  <= '0;
        end else if (accept) begin
            tick_q <= '0;
            bit_q  <= '0;
        end else if (state_q != IDLE && baud_x16_ce) begin
            tick_q <= tick_q + TW'(1);
            if (bit_end)
                bit_q <= (state_d != state_q) ? 3'd0 : bit_q + 3'd1;
        end
    end

    always_comb begin
        shreg_d = shreg_q;
        if (accept)
            shreg_d = tx_data;
        else if (state_q == DATA && bit_end)
            shreg_d = {1'b0, shreg_q[UART_DATA_BITS-1:1]};
    end

    // Frame configuration is frozen at accept so mid-frame input changes are harmless
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shreg_q    <= '0;
            par_en_q   <= 1'b0;
            par_bit_q  <= 1'b0;
            two_stop_q <= 1'b0;
        end else begin
            shreg_q <= shreg_d;
            if (accept) begin
                par_en_q   <= parity_en;
                par_bit_q  <= uart_parity(tx_data, parity_odd);
                two_stop_q <= two_stop;
            end
        end
    end

    // Output logic: line level follows the state being entered, so it is registered
    always_comb begin
        tx_d   = 1'b1;
        done_d = (state_q == STOP) && (state_d == IDLE);
        unique case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shreg_d[0];
            PARITY:  tx_d = par_bit_q;
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_q   <= 1'b1;
            done_q <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            tx_q   <= tx_d;
            done_q <= done_d;
            busy_q <= (state_d != IDLE);
        end
    end

    assign tx_o    = tx_q;
    assign tx_busy = busy_q;
    assign tx_done = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed and random frames checked against a bit-list model of the UART frame;
// the model counts enable pulses per expected line level.
module tb_uart_tx;

    localparam int OS = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       baud_x16_ce = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_en = 1'b0;
    logic       parity_en = 1'b0;
    logic       parity_odd = 1'b0;
    logic       two_stop = 1'b0;
    logic       tx_o, tx_busy, tx_done;

    logic       stall = 1'b0;
    int         div = 0;
    int         n_chk = 0;
    int         n_fail = 0;
    logic       exp_q[$];

    uart_tx #(.OVERSAMPLE(OS)) dut (
        .clk         (clk),
        .reset       (reset),
        .baud_x16_ce (baud_x16_ce),
        .tx_data     (tx_data),
        .tx_en       (tx_en),
        .parity_en   (parity_en),
        .parity_odd  (parity_odd),
        .two_stop    (two_stop),
        .tx_o        (tx_o),
        .tx_busy     (tx_busy),
        .tx_done     (tx_done)
    );

    always #5 clk = ~clk;

    // Enable every third clock, updated mid-cycle so it is stable at both edges
    always @(posedge clk) begin
        #2;
        if (stall) begin
            baud_x16_ce = 1'b0;
        end else begin
            div = (div + 1) % 3;
            baud_x16_ce = (div == 0);
        end
    end

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic build_frame(input logic [7:0] d, input bit pe, input bit po, input bit ts);
        exp_q = {};
        exp_q.push_back(1'b0);
        for (int i = 0; i < 8; i++) exp_q.push_back(d[i]);
        if (pe) exp_q.push_back(logic'((($countones(d) % 2) == 1) ^ po));
        exp_q.push_back(1'b1);
        if (ts) exp_q.push_back(1'b1);
    endtask

    task automatic send(input logic [7:0] d, input bit pe, input bit po, input bit ts);
        @(negedge clk);
        tx_en = 1'b1; tx_data = d; parity_en = pe; parity_odd = po; two_stop = ts;
        @(negedge clk);
        tx_en = 1'b0;
    endtask

    // Entered at the first falling edge after the accepting edge.
    task automatic check_frame(input logic [7:0] d, input bit pe, input bit po, input bit ts,
                               input int inj_cyc, input int stall_cyc, input int rst_bit,
                               input bit nxt, input logic [7:0] nd,
                               input bit npe, input bit npo, input bit nts);
        int bi  = 0;
        int tk  = 0;
        int cyc = 0;
        build_frame(d, pe, po, ts);
        while (bi < exp_q.size()) begin
            if (cyc > 6000) begin
                chk("frame_timeout", logic'(bi >= exp_q.size()), 1'b1);
                stall = 1'b0;
                break;
            end
            chk("tx_o", tx_o, exp_q[bi]);
            chk("tx_busy", tx_busy, 1'b1);
            chk("tx_done_mid", tx_done, 1'b0);
            if (rst_bit == bi && tk == 5) begin
                reset = 1'b0;
                #1;
                chk("rst_tx_o", tx_o, 1'b1);
                chk("rst_busy", tx_busy, 1'b0);
                chk("rst_done", tx_done, 1'b0);
                @(negedge clk);
                reset = 1'b1;
                repeat (3) begin
                    @(negedge clk);
                    chk("post_rst_tx_o", tx_o, 1'b1);
                    chk("post_rst_busy", tx_busy, 1'b0);
                    chk("post_rst_done", tx_done, 1'b0);
                end
                return;
            end
            if (cyc == inj_cyc) begin
                tx_en = 1'b1; tx_data = 8'hFF;
                parity_en = ~parity_en; parity_odd = ~parity_odd; two_stop = ~two_stop;
            end
            if (cyc == inj_cyc + 1) tx_en = 1'b0;
            stall = (stall_cyc >= 0) && (cyc >= stall_cyc) && (cyc < stall_cyc + 1000);
            if (baud_x16_ce) begin
                tk++;
                if (tk == OS) begin
                    tk = 0;
                    bi++;
                end
            end
            @(negedge clk);
            cyc++;
        end
        chk("end_tx_o", tx_o, 1'b1);
        chk("end_busy", tx_busy, 1'b0);
        chk("end_done", tx_done, 1'b1);
        if (nxt) begin
            tx_en = 1'b1; tx_data = nd; parity_en = npe; parity_odd = npo; two_stop = nts;
        end
        @(negedge clk);
        tx_en = 1'b0;
        chk("done_one_cycle", tx_done, 1'b0);
        chk("after_busy", tx_busy, nxt);
        chk("after_tx_o", tx_o, !nxt);
    endtask

    initial begin
        logic [7:0] rd;
        bit         rpe, rpo, rts;

        #1 reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_tx_o", tx_o, 1'b1);
        chk("reset_busy", tx_busy, 1'b0);
        chk("reset_done", tx_done, 1'b0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        send(8'h55, 0, 0, 0);
        check_frame(8'h55, 0, 0, 0, -1, -1, -1, 0, 8'h00, 0, 0, 0);

        send(8'hA3, 1, 0, 0);
        check_frame(8'hA3, 1, 0, 0, -1, -1, -1, 0, 8'h00, 0, 0, 0);

        send(8'h00, 1, 1, 1);
        check_frame(8'h00, 1, 1, 1, -1, -1, -1, 0, 8'h00, 0, 0, 0);

        // request ignored mid-frame, then back-to-back request in the done cycle
        send(8'h12, 0, 0, 0);
        check_frame(8'h12, 0, 0, 0, 200, -1, -1, 1, 8'h34, 1, 1, 0);
        check_frame(8'h34, 1, 1, 0, -1, -1, -1, 0, 8'h00, 0, 0, 0);

        send(8'h5A, 0, 0, 0);
        check_frame(8'h5A, 0, 0, 0, -1, -1, 4, 0, 8'h00, 0, 0, 0);
        send(8'h81, 0, 0, 0);
        check_frame(8'h81, 0, 0, 0, -1, -1, -1, 0, 8'h00, 0, 0, 0);

        send(8'hC6, 1, 0, 1);
        check_frame(8'hC6, 1, 0, 1, -1, 301, -1, 0, 8'h00, 0, 0, 0);

        for (int k = 0; k < 4; k++) begin
            rd  = 8'($urandom);
            rpe = 1'($urandom);
            rpo = 1'($urandom);
            rts = 1'($urandom);
            send(rd, rpe, rpo, rts);
            check_frame(rd, rpe, rpo, rts, -1, -1, -1, 0, 8'h00, 0, 0, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
